// File: rtl/lcd_bus_arbiter_if.sv
// Handshake and pin bundle between the two byte requesters, the arbiter and the LCD write bus.
// master: requester/pin side view; slave: arbiter view.
interface lcd_bus_arbiter_if;
    logic       init_valid;
    logic       init_dcx;
    logic [7:0] init_data;
    logic       init_last;
    logic       init_ready;
    logic       pix_valid;
    logic       pix_dcx;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       pix_ready;
    logic       dcx;
    logic       wr;
    logic [7:0] D;
    logic       busy;
    logic       owner;

    modport master (
        output init_valid, init_dcx, init_data, init_last,
        output pix_valid, pix_dcx, pix_data, pix_last,
        input  init_ready, pix_ready,
        input  dcx, wr, D, busy, owner
    );

    modport slave (
        input  init_valid, init_dcx, init_data, init_last,
        input  pix_valid, pix_dcx, pix_data, pix_last,
        output init_ready, pix_ready,
        output dcx, wr, D, busy, owner
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates two byte streams onto the 8080 LCD write bus, one transaction per grant.
// Latency: wr falls the cycle after acceptance; one byte per 1+WR_LOW_CYC+WR_HIGH_CYC cycles.
// Backpressure: ready only in IDLE; a locked owner blocks the other port until its last byte.
module lcd_bus_arbiter #(
    parameter int WR_LOW_CYC  = 1,
    parameter int WR_HIGH_CYC = 1
) (
    input  logic               hwclk,
    input  logic               nrst,
    lcd_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_e;

    localparam logic [3:0] LO_LOAD = 4'(WR_LOW_CYC - 1);
    localparam logic [3:0] HI_LOAD = 4'(WR_HIGH_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       locked_q, locked_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic       dcx_q, dcx_d;
    logic [7:0] data_q, data_d;

    logic init_rdy;
    logic pix_rdy;
    logic take_init;
    logic take_pix;

    // Grant decision: a held lock pins the bus to its owner, otherwise port 0 wins ties.
    always_comb begin
        init_rdy = 1'b0;
        pix_rdy  = 1'b0;
        if (state_q == IDLE) begin
            if (locked_q) begin
                init_rdy = ~owner_q;
                pix_rdy  = owner_q;
            end else begin
                init_rdy = 1'b1;
                pix_rdy  = ~bus.init_valid;
            end
        end
    end

    assign take_init = bus.init_valid & init_rdy;
    assign take_pix  = bus.pix_valid & pix_rdy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        dcx_d    = dcx_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (take_init) begin
                    data_d   = bus.init_data;
                    dcx_d    = bus.init_dcx;
                    owner_d  = 1'b0;
                    locked_d = ~bus.init_last;
                    cnt_d    = LO_LOAD;
                    wr_d     = 1'b0;
                    state_d  = WR_LO;
                end else if (take_pix) begin
                    data_d   = bus.pix_data;
                    dcx_d    = bus.pix_dcx;
                    owner_d  = 1'b1;
                    locked_d = ~bus.pix_last;
                    cnt_d    = LO_LOAD;
                    wr_d     = 1'b0;
                    state_d  = WR_LO;
                end
            end
            WR_LO: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = HI_LOAD;
                    wr_d    = 1'b1;
                    state_d = WR_HI;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HI: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                wr_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
            wr_q     <= 1'b1;
            dcx_q    <= 1'b1;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            dcx_q    <= dcx_d;
            data_q   <= data_d;
        end
    end

    assign bus.init_ready = init_rdy;
    assign bus.pix_ready  = pix_rdy;
    assign bus.wr         = wr_q;
    assign bus.dcx        = dcx_q;
    assign bus.D          = data_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q != IDLE) | locked_q;

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the 8-bit 8080-style LCD write bus (dcx, wr, D) between two byte-stream requesters: the panel init/configuration sequencer (port 0) and the pixel/cursor draw engine (port 1). Each requester hands over bytes on a valid/ready handshake and frames a command plus its data as one transaction. The arbiter grants the bus per transaction and sequences every byte into a wr-strobe cycle of parameterised width. It sits between those two engines and the top-level dcx/wr/D pins.

## Interface
- WR_LOW_CYC, 1, cycles wr is held low per byte (1..15)
- WR_HIGH_CYC, 1, cycles wr is held high after the rising edge before the next byte (1..15)
- hwclk  in  1  system clock; all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- init_valid  in  1  port 0 has a byte
- init_dcx  in  1  port 0 byte type: 0 command, 1 data
- init_data  in  8  port 0 byte
- init_last  in  1  port 0 byte ends its transaction
- init_ready  out  1  port 0 byte accepted this cycle when init_valid=1
- pix_valid, pix_dcx, pix_data[7:0], pix_last  in  1/1/8/1  port 1, same meaning
- pix_ready  out  1  port 1 handshake
- dcx  out  1  LCD data/command select
- wr  out  1  LCD write strobe, active-low; panel latches D on rising edge
- D  out  8  LCD data bus
- busy  out  1  strobe cycle in progress or transaction lock held
- owner  out  1  current/last granted port (0 init, 1 pix)

## Operation
- State machine IDLE, WR_LO, WR_HI; 4-bit phase counter.
- Lock: locked flag plus owner register. Accepted byte with last=0 sets locked, owner=port; accepted byte with last=1 clears locked.
- Ready (combinational, only in IDLE):
  - locked: only owner's ready is 1.
  - unlocked: init_ready=1; pix_ready = ~init_valid (fixed priority, port 0 wins ties).
- Transfer = valid & ready at a rising edge: capture data into D, dcx_in into dcx, set owner, load counter, go to WR_LO.
- WR_LO: wr=0 for WR_LOW_CYC cycles, then WR_HI.
- WR_HI: wr=1 for WR_HIGH_CYC cycles, then IDLE.
- D and dcx hold the last captured values until the next transfer; they never change while wr=0.
- Locked owner with valid=0: stay in IDLE with wr=1, other port not served; no timeout.
- Single-byte transaction (last=1 on first byte) never sets locked.
- busy = (state != IDLE) | locked.

## Timing
- Reset values: wr=1, dcx=1, D=8'h00, owner=0, locked=0, state=IDLE, init_ready=1 and pix_ready=1 combinationally (both valid=0).
- Reset assertion mid-strobe: wr returns high asynchronously; lock and any in-flight byte are discarded; requesters resend.
- Byte accepted at edge N: wr falls after edge N, rises after edge N+WR_LOW_CYC, next ready no earlier than the cycle after edge N+WR_LOW_CYC+WR_HIGH_CYC.
- Throughput: one byte per 1+WR_LOW_CYC+WR_HIGH_CYC cycles; defaults give 3.
- Arbitration is decided only in IDLE while unlocked; a pending request on the other port waits until the owner's last byte completes its WR_HI phase.
- D/dcx setup to wr falling edge is 0 cycles (same edge); setup to wr rising edge is WR_LOW_CYC cycles; hold after rising edge is ≥ WR_HIGH_CYC cycles.

## Test plan
- Reset: drive nrst low mid-WR_LO -> wr=1 immediately, D=00, dcx=1, busy=0, both ready=1 after release.
- Single port 0 transaction: cmd 8'h2A (dcx=0) then 00,00,00,EF (last on EF) at defaults -> five wr low pulses 3 cycles apart, D/dcx match each byte at each wr rise, busy falls after final WR_HI.
- Tie: init_valid and pix_valid rise together, both unlocked -> init_ready=1, pix_ready=0; init byte goes first.
- Lock hold: port 1 sends 8'h2C (last=0), then drops valid for 10 cycles while port 0 requests -> init_ready stays 0, wr stays 1; port 1 resumes with last byte, then port 0 is granted next.
- Parameters WR_LOW_CYC=3, WR_HIGH_CYC=2: back-to-back bytes -> wr low exactly 3 cycles, high 2, byte period 6 cycles.
- Single-byte transactions alternating ports with both valid always 1 -> port 0 wins every arbitration (starves port 1), owner stays 0, lock never set.
